// File: rtl/priority_scan_encoder.sv
// Multi-hot request vector in, one binary index per set bit out, in priority order.
// Valid/ready on both sides; a new vector is taken only once the previous one has fully drained.
module priority_scan_encoder #(
   parameter int N         = 4,
   parameter bit MSB_FIRST = 1'b1,
   localparam int W        = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] in_req,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] out_code,
   output logic         out_last,
   output logic         out_none,
   output logic         out_valid,
   input  logic         out_ready
);

   // Handshake: a transfer happens on a rising edge where valid && ready are both high.
   // Producers never make valid depend on ready; ready may depend on valid.

   localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

   logic [N-1:0] pend;
   logic         slot_free;
   logic         accept;
   logic [N-1:0] src;
   logic [W-1:0] pick_code;
   logic [N-1:0] pick_rem;

   function automatic logic [W-1:0] prio_index(input logic [N-1:0] vec);
      logic [W-1:0] idx;
      idx = '0;
      if (MSB_FIRST) begin
         for (int i = 0; i < N; i++) begin
            if (vec[i]) idx = W'(i);
         end
      end else begin
         for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = W'(i);
         end
      end
      return idx;
   endfunction

   always_comb begin
      slot_free = !out_valid || out_ready;
      in_ready  = !rst && (pend == '0) && slot_free;
      accept    = in_valid && in_ready;
      // Draining and accepting never overlap, so one picker serves both.
      src       = (pend != '0) ? pend : in_req;
      pick_code = prio_index(src);
      pick_rem  = src & ~(ONE << pick_code);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend      <= '0;
         out_valid <= 1'b0;
         out_code  <= '0;
         out_last  <= 1'b0;
         out_none  <= 1'b0;
      end else if (slot_free) begin
         if ((pend != '0) || (accept && (in_req != '0))) begin
            out_code  <= pick_code;
            pend      <= pick_rem;
            out_last  <= (pick_rem == '0);
            out_none  <= 1'b0;
            out_valid <= 1'b1;
         end else if (accept) begin
            out_code  <= '0;
            out_last  <= 1'b1;
            out_none  <= 1'b1;
            out_valid <= 1'b1;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
